// File: rtl/iq_unpack_pkg.sv
// Shared types and arithmetic for the iq_unpack byte-stream deframer.
package iq_unpack_pkg;

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } iq_unpack_state_t;

    // Sign-extend an in_width-bit sample, shift left by bits, keep out_width LSBs (wraps).
    function automatic logic [63:0] quantize_sext(input logic [63:0] sample,
                                                  input int in_width,
                                                  input int out_width,
                                                  input int bits);
        logic signed [63:0] ext;
        logic [63:0]        shifted;
        logic [63:0]        mask;
        ext     = $signed(sample << (64 - in_width));
        ext     = ext >>> (64 - in_width);
        shifted = ext << bits;
        mask    = {64{1'b1}} >> (64 - out_width);
        return shifted & mask;
    endfunction

endpackage

// File: rtl/iq_sample_assembler.sv
// Per-channel sample register: writes one byte into a selected byte slot per load.
module iq_sample_assembler
    import iq_unpack_pkg::*;
#(
    parameter int BYTE_SIZE        = 8,
    parameter int BYTES_PER_SAMPLE = 2,
    parameter int SLOT_W           = 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [BYTE_SIZE-1:0]                  byte_i,
    input  logic [SLOT_W-1:0]                     slot_i,
    input  logic                                  load_i,
    input  logic                                  clear_i,
    output logic [BYTES_PER_SAMPLE*BYTE_SIZE-1:0] sample_o
);

    logic [BYTES_PER_SAMPLE*BYTE_SIZE-1:0] sample_q, sample_d;

    always_comb begin
        sample_d = sample_q;
        if (clear_i) begin
            sample_d = '0;
        end else if (load_i) begin
            for (int s = 0; s < BYTES_PER_SAMPLE; s++) begin
                if (slot_i == SLOT_W'(s)) begin
                    sample_d[s*BYTE_SIZE +: BYTE_SIZE] = byte_i;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/iq_unpack.sv
// Deframes interleaved multi-channel sample bytes from a FWFT FIFO and writes
// one quantized word per channel to the downstream FIFOs in a single cycle.
module iq_unpack
    import iq_unpack_pkg::*;
#(
    parameter int DATA_SIZE        = 32,
    parameter int BYTE_SIZE        = 8,
    parameter int BYTES_PER_SAMPLE = 2,
    parameter int NUM_CH           = 2,
    parameter int BITS             = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [BYTE_SIZE-1:0]          in_dout,
    input  logic                          in_empty,
    output logic                          in_rd_en,
    input  logic                          big_endian,
    input  logic [NUM_CH-1:0]             out_full,
    output logic                          out_wr_en,
    output logic [NUM_CH*DATA_SIZE-1:0]   out_data,
    output logic [31:0]                   frame_count
);

    localparam int SW = BYTES_PER_SAMPLE * BYTE_SIZE;
    localparam int BW = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES_PER_SAMPLE - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

    iq_unpack_state_t state_q, state_d;
    logic [BW-1:0]    byte_idx_q, byte_idx_d;
    logic [CW-1:0]    ch_idx_q, ch_idx_d;
    logic             frame_be_q, frame_be_d;
    logic [31:0]      frame_count_q, frame_count_d;
    logic             first_byte, be_now, load, clear;
    logic [BW-1:0]    slot;

    // The first byte of a frame uses the live select; later bytes use the latched one.
    assign first_byte = (byte_idx_q == '0) && (ch_idx_q == '0);
    assign be_now     = first_byte ? big_endian : frame_be_q;
    assign slot       = be_now ? (BYTE_LAST - byte_idx_q) : byte_idx_q;

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        ch_idx_d      = ch_idx_q;
        frame_be_d    = frame_be_q;
        frame_count_d = frame_count_q;
        in_rd_en      = 1'b0;
        out_wr_en     = 1'b0;
        load          = 1'b0;
        clear         = 1'b0;
        case (state_q)
            S_READ: begin
                if (!in_empty && !reset) begin
                    in_rd_en = 1'b1;
                    load     = 1'b1;
                    if (first_byte) begin
                        frame_be_d = big_endian;
                    end
                    if (byte_idx_q == BYTE_LAST) begin
                        byte_idx_d = '0;
                        if (ch_idx_q == CH_LAST) begin
                            ch_idx_d = '0;
                            state_d  = S_WRITE;
                        end else begin
                            ch_idx_d = ch_idx_q + 1'b1;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (out_full == '0) begin
                    out_wr_en     = 1'b1;
                    frame_count_d = frame_count_q + 32'd1;
                    state_d       = S_READ;
                end
            end
            default: begin
                state_d    = S_READ;
                byte_idx_d = '0;
                ch_idx_d   = '0;
                clear      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_READ;
            byte_idx_q    <= '0;
            ch_idx_q      <= '0;
            frame_be_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            ch_idx_q      <= ch_idx_d;
            frame_be_q    <= frame_be_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SW-1:0] sample;

        iq_sample_assembler #(
            .BYTE_SIZE        (BYTE_SIZE),
            .BYTES_PER_SAMPLE (BYTES_PER_SAMPLE),
            .SLOT_W           (BW)
        ) u_asm (
            .clock    (clock),
            .reset    (reset),
            .byte_i   (in_dout),
            .slot_i   (slot),
            .load_i   (load && (ch_idx_q == CW'(c))),
            .clear_i  (clear),
            .sample_o (sample)
        );

        assign out_data[c*DATA_SIZE +: DATA_SIZE] =
            DATA_SIZE'(quantize_sext(64'(sample), SW, DATA_SIZE, BITS));
    end

endmodule

// File: tb/tb_iq_unpack.sv
// Scoreboard bench for iq_unpack: default 2ch/2-byte instance plus a 4ch/3-byte instance.
module tb_iq_unpack;
    import iq_unpack_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0]   in_dout, in_dout4;
    logic         in_empty, in_empty4, in_rd_en, in_rd_en4;
    logic         big_endian, big_endian4, out_wr_en, out_wr_en4;
    logic [1:0]   out_full;
    logic [3:0]   out_full4;
    logic [63:0]  out_data;
    logic [127:0] out_data4;
    logic [31:0]  frame_count, frame_count4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pop4_cyc = 0;
    logic [63:0]  exp_q[$];
    logic [127:0] exp4_q[$];

    iq_unpack u_dut (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .big_endian(big_endian), .out_full(out_full),
        .out_wr_en(out_wr_en), .out_data(out_data), .frame_count(frame_count)
    );

    iq_unpack #(.BYTES_PER_SAMPLE(3), .NUM_CH(4), .BITS(0)) u_dut4 (
        .clock(clock), .reset(reset), .in_dout(in_dout4), .in_empty(in_empty4),
        .in_rd_en(in_rd_en4), .big_endian(big_endian4), .out_full(out_full4),
        .out_wr_en(out_wr_en4), .out_data(out_data4), .frame_count(frame_count4)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && out_wr_en === 1'b1) begin
            check("rd_wr_exclusive", 128'(in_rd_en), 128'(1'b0));
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got data %h expected no write", out_data);
            end else begin
                check("frame_data", 128'(out_data), 128'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clock) begin
        if (reset === 1'b0 && out_wr_en4 === 1'b1) begin
            check("latency4", 128'(cyc - pop4_cyc), 128'(12));
            if (exp4_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write4: got data %h expected no write", out_data4);
            end else begin
                check("frame_data4", out_data4, exp4_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic be);
        int  n;
        logic took;
        n = 0;
        took = 1'b0;
        while (!took && n < 200) begin
            @(posedge clock); #1;
            in_dout = b; big_endian = be; in_empty = 1'b0;
            #1 took = in_rd_en;
            n++;
        end
        if (!took) begin
            failures++;
            $display("FAIL send_byte_timeout: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_byte4(input logic [7:0] b, input bit first);
        int  n;
        logic took;
        n = 0;
        took = 1'b0;
        while (!took && n < 200) begin
            @(posedge clock); #1;
            in_dout4 = b; in_empty4 = 1'b0;
            #1 took = in_rd_en4;
            n++;
        end
        if (first) pop4_cyc = cyc;
        if (!took) begin
            failures++;
            $display("FAIL send_byte4_timeout: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1 in_empty = 1'b1;
        end
    endtask

    // bytes[31:24] goes first; be[3-i] is the big_endian level shown with byte i.
    task automatic send_frame(input logic [31:0] bytes, input logic [3:0] be,
                              input bit bubbles, input bit finish);
        for (int i = 0; i < 4; i++) begin
            if (bubbles && $urandom_range(0, 1) == 1) begin
                @(posedge clock); #1;
                in_empty = 1'b1; in_dout = 8'($urandom);
            end
            send_byte(bytes[31-8*i -: 8], be[3-i]);
        end
        if (finish) begin
            @(posedge clock); #1 in_empty = 1'b1;
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] bytes, input logic be);
        logic [15:0] i_s, q_s;
        logic [63:0] i_w, q_w;
        i_s = be ? bytes[31:16] : {bytes[23:16], bytes[31:24]};
        q_s = be ? bytes[15:0]  : {bytes[7:0], bytes[15:8]};
        i_w = quantize_sext(64'(i_s), 16, 32, 10);
        q_w = quantize_sext(64'(q_s), 16, 32, 10);
        return {q_w[31:0], i_w[31:0]};
    endfunction

    initial begin
        logic [95:0]  bytes4;
        logic [31:0]  rb;
        logic [3:0]   rbe;
        reset = 1'b1;
        in_empty = 1'b1; in_empty4 = 1'b1;
        in_dout = '0; in_dout4 = '0;
        big_endian = 1'b0; big_endian4 = 1'b0;
        out_full = '0; out_full4 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_rd_en", 128'(in_rd_en), 128'(1'b0));
        check("reset_wr_en", 128'(out_wr_en), 128'(1'b0));
        check("reset_out_data", 128'(out_data), 128'(64'd0));
        check("reset_frame_count", 128'(frame_count), 128'(32'd0));
        check("reset_out_data4", out_data4, 128'd0);
        reset = 1'b0;

        // 4 channels x 3 bytes, BITS=0
        bytes4 = 96'h010000_FFFF7F_000080_FFFFFF;
        exp4_q.push_back({32'hFFFFFFFF, 32'hFF800000, 32'h007FFFFF, 32'h00000001});
        for (int i = 0; i < 12; i++) send_byte4(bytes4[95-8*i -: 8], i == 0);
        @(posedge clock); #1 in_empty4 = 1'b1;
        repeat (3) @(posedge clock);
        #1 check("frame_count4", 128'(frame_count4), 128'(32'd1));

        // little-endian
        exp_q.push_back({32'hFFFFFC00, 32'h0048D000});
        send_frame(32'h3412FFFF, 4'b0000, 1'b0, 1'b1);
        idle(2);
        check("frame_count_le", 128'(frame_count), 128'(32'd1));

        // big-endian latched at frame start, select dropped mid-frame
        exp_q.push_back({32'h00000400, 32'hFE000000});
        send_frame(32'h80000001, 4'b1100, 1'b0, 1'b1);
        idle(2);
        check("frame_count_be", 128'(frame_count), 128'(32'd2));

        // backpressure from channel 1 held at the write state
        out_full = 2'b10;
        exp_q.push_back({32'h00000800, 32'h00000400});
        send_frame(32'h01000200, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            in_empty = 1'b0; in_dout = 8'hEE;
            #1;
            check("hold_wr_en", 128'(out_wr_en), 128'(1'b0));
            check("hold_rd_en", 128'(in_rd_en), 128'(1'b0));
            check("hold_data", 128'(out_data), 128'({32'h00000800, 32'h00000400}));
        end
        @(posedge clock); #1 out_full = 2'b00;
        #1 check("release_wr_en", 128'(out_wr_en), 128'(1'b1));
        @(posedge clock); #1 in_empty = 1'b1;
        idle(2);
        check("frame_count_bp", 128'(frame_count), 128'(32'd3));

        // reset mid-frame discards the partial frame
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        @(posedge clock); #1;
        in_empty = 1'b1; reset = 1'b1;
        #1;
        check("midreset_frame_count", 128'(frame_count), 128'(32'd0));
        check("midreset_out_data", 128'(out_data), 128'(64'd0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_q.push_back({32'hFE000000, 32'h0159E000});
        send_frame(32'h78560080, 4'b0000, 1'b0, 1'b1);
        idle(3);
        check("frame_count_after_reset", 128'(frame_count), 128'(32'd1));

        // random frames with input bubbles against the package model
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int f = 0; f < 1000; f++) begin
            rb  = $urandom;
            rbe = 4'($urandom);
            exp_q.push_back(model(rb, rbe[3]));
            send_frame(rb, rbe, 1'b1, 1'b1);
        end
        idle(5);
        check("frame_count_random", 128'(frame_count), 128'(32'd1000));
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        check("scoreboard4_drained", 128'(exp4_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
